// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: instruction fields from the MEM stage and the register-file write port.
// The MEM side drives the in_* fields (master); the WB stage consumes them (slave).
interface mem_wb_stage_if;
  logic        in_valid;
  logic        in_RegWrite;
  logic [4:0]  in_WeSel;
  logic [31:0] in_AluResult;
  logic [31:0] in_MemData;
  logic [31:0] in_PC4;
  logic [1:0]  in_WbSrc;
  logic [2:0]  in_LdType;

  logic        WE;
  logic [4:0]  WeSel;
  logic [31:0] WData;
  logic        wb_valid;
  logic [31:0] retired;

  modport master (
    output in_valid, in_RegWrite, in_WeSel, in_AluResult, in_MemData, in_PC4,
           in_WbSrc, in_LdType,
    input  WE, WeSel, WData, wb_valid, retired
  );

  modport slave (
    input  in_valid, in_RegWrite, in_WeSel, in_AluResult, in_MemData, in_PC4,
           in_WbSrc, in_LdType,
    output WE, WeSel, WData, wb_valid, retired
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback mux and retired-instruction counter.
// Define MEM_WB_SUBWORD_EN to enable lb/lbu/lh/lhu extraction; otherwise every load is lw.
module mem_wb_stage (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  mem_wb_stage_if.slave   bus
);

  logic        valid_q;
  logic        regwrite_q;
  logic [4:0]  wesel_q;
  logic [31:0] alu_q;
  logic [31:0] mem_q;
  logic [31:0] pc4_q;
  logic [1:0]  wbsrc_q;
  logic [31:0] retired_q;
  logic [31:0] retired_d;
  logic [31:0] load_data;
  logic [31:0] wdata;

`ifdef MEM_WB_SUBWORD_EN
  logic [2:0]  ldtype_q;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
`else
  logic        unused_ldtype;
  assign unused_ldtype = ^bus.in_LdType;
`endif

  // Flush wins over stall: the held instruction becomes a bubble either way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wesel_q    <= 5'd0;
      alu_q      <= 32'd0;
      mem_q      <= 32'd0;
      pc4_q      <= 32'd0;
      wbsrc_q    <= 2'b00;
`ifdef MEM_WB_SUBWORD_EN
      ldtype_q   <= 3'b000;
`endif
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= bus.in_valid;
      regwrite_q <= bus.in_RegWrite;
      wesel_q    <= bus.in_WeSel;
      alu_q      <= bus.in_AluResult;
      mem_q      <= bus.in_MemData;
      pc4_q      <= bus.in_PC4;
      wbsrc_q    <= bus.in_WbSrc;
`ifdef MEM_WB_SUBWORD_EN
      ldtype_q   <= bus.in_LdType;
`endif
    end
  end

  // An instruction leaving the stage retires whenever the stage is not stalled, flush or not.
  always_comb begin
    retired_d = retired_q;
    if (valid_q && !stall) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= 32'd0;
    else        retired_q <= retired_d;
  end

  always_comb begin
    load_data = mem_q;
`ifdef MEM_WB_SUBWORD_EN
    case (alu_q[1:0])
      2'd0:    byte_lane = mem_q[7:0];
      2'd1:    byte_lane = mem_q[15:8];
      2'd2:    byte_lane = mem_q[23:16];
      default: byte_lane = mem_q[31:24];
    endcase
    half_lane = alu_q[1] ? mem_q[31:16] : mem_q[15:0];
    case (ldtype_q)
      3'b001:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b010:  load_data = {24'd0, byte_lane};
      3'b011:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {16'd0, half_lane};
      default: load_data = mem_q;
    endcase
`endif
    case (wbsrc_q)
      2'b01:   wdata = load_data;
      2'b10:   wdata = pc4_q;
      default: wdata = alu_q;
    endcase
  end

  // x0 is hardwired zero, so a write to index 0 is dropped but still retires.
  assign bus.WE       = valid_q & regwrite_q & (wesel_q != 5'd0) & ~stall;
  assign bus.WeSel    = wesel_q;
  assign bus.WData    = wdata;
  assign bus.wb_valid = valid_q;
  assign bus.retired  = retired_q;

endmodule
